// File: rtl/zz_pingpong_buf.sv
// zz_pingpong_buf: two-bank 8x8 block reorder buffer between the quantiser and
// the entropy coder. One bank fills while the other drains, so a steady stream
// moves at one word per clock. MODE picks raster, zigzag or inverse-zigzag reorder.
//
// Handshake: a word moves on a rising clk edge where valid && ready are both high.
// in_ready depends only on registered state, never on in_valid. Once out_valid is
// high, out_data/out_last stay stable until the edge where out_ready is high.
module zz_pingpong_buf #(
    parameter int DATA_W = 8,
    parameter int MODE   = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic              out_last
);

    // Raster index of each zigzag scan position.
    localparam int ZZ [64] = '{
         0,  1,  8, 16,  9,  2,  3, 10, 17, 24, 32, 25, 18, 11,  4,  5,
        12, 19, 26, 33, 40, 48, 41, 34, 27, 20, 13,  6,  7, 14, 21, 28,
        35, 42, 49, 56, 57, 50, 43, 36, 29, 22, 15, 23, 30, 37, 44, 51,
        58, 59, 52, 45, 38, 31, 39, 46, 53, 60, 61, 54, 47, 55, 62, 63
    };

    // Both banks in one array; the top address bit selects the bank.
    logic [DATA_W-1:0] mem [0:127];

    logic       wr_bank;
    logic       rd_bank;
    logic [5:0] wr_cnt;
    logic [5:0] rd_cnt;
    logic [1:0] full;
    logic [1:0] full_nxt;
    logic       wr_fire;
    logic       load;
    logic [5:0] wa;
    logic [5:0] ra;

    assign in_ready = !full[wr_bank];
    assign wr_fire  = in_valid && in_ready;
    // The output register may be refilled when empty or when its word is taken.
    assign load     = full[rd_bank] && (!out_valid || out_ready);
    assign wa       = (MODE == 2) ? 6'(ZZ[wr_cnt]) : wr_cnt;
    assign ra       = (MODE == 1) ? 6'(ZZ[rd_cnt]) : rd_cnt;

    // Write port: store accepted words into the filling bank (contents never reset).
    always_ff @(posedge clk) begin
        if (wr_fire) begin
            mem[{wr_bank, wa}] <= in_data;
        end
    end

    // Full flags: writer sets the bank it completes, reader clears the bank it empties.
    // They always act on different banks, so both may happen in the same cycle.
    always_comb begin
        full_nxt = full;
        if (wr_fire && (wr_cnt == 6'd63)) begin
            full_nxt[wr_bank] = 1'b1;
        end
        if (load && (rd_cnt == 6'd63)) begin
            full_nxt[rd_bank] = 1'b0;
        end
    end

    // Counters, bank pointers and full flags.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_bank <= 1'b0;
            rd_bank <= 1'b0;
            wr_cnt  <= 6'd0;
            rd_cnt  <= 6'd0;
            full    <= 2'b00;
        end else begin
            full <= full_nxt;
            if (wr_fire) begin
                wr_cnt <= wr_cnt + 6'd1;
                if (wr_cnt == 6'd63) begin
                    wr_bank <= !wr_bank;
                end
            end
            if (load) begin
                rd_cnt <= rd_cnt + 6'd1;
                if (rd_cnt == 6'd63) begin
                    rd_bank <= !rd_bank;
                end
            end
        end
    end

    // Registered output stage: load the next reordered word or retire the taken one.
    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid <= 1'b0;
            out_last  <= 1'b0;
            out_data  <= '0;
        end else if (load) begin
            out_data  <= mem[{rd_bank, ra}];
            out_valid <= 1'b1;
            out_last  <= (rd_cnt == 6'd63);
        end else if (out_valid && out_ready) begin
            out_valid <= 1'b0;
            out_last  <= 1'b0;
        end
    end

endmodule
